hamming_encoder_7_4_tx: RTL and testbench

//  Serial Hamming(7,4) encoder/transmitter: the transmit end of the Hamming(7,4) serial link.

---
 rtl/hamming_encoder_7_4_tx_pkg.sv | 12 +
 rtl/hamming_parity_7_4.sv | 26 ++
 rtl/hamming_encoder_7_4_tx.sv | 92 +++++++++
 tb/tb_hamming_encoder_7_4_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_encoder_7_4_tx_pkg.sv
// Shared Hamming(7,4) link definitions: frame geometry and transmitter state encodings.
// The serial decoder imports the same package, so both ends agree on bit order.
package hamming_encoder_7_4_tx_pkg;

  localparam int HAM_CW_LEN   = 7;
  localparam int HAM_DATA_LEN = 4;
  localparam logic [2:0] HAM_IDX_LAST = 3'd6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;

endpackage

// File: rtl/hamming_parity_7_4.sv
// Combinational Hamming(7,4) codeword builder; codeword[0] is position 1 (p1), sent first.
// Layout by position: p1 p2 d1 p3 d2 d3 d4.
module hamming_parity_7_4
  import hamming_encoder_7_4_tx_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic [HAM_DATA_LEN-1:0] data,
  output logic [HAM_CW_LEN-1:0]   codeword
);

  logic d1, d2, d3, d4;
  logic p1, p2, p3;

  always_comb begin
    d1 = data[0];
    d2 = data[1];
    d3 = data[2];
    d4 = data[3];
    p1 = d1 ^ d2 ^ d4 ^ ODD_PARITY;
    p2 = d1 ^ d3 ^ d4 ^ ODD_PARITY;
    p3 = d2 ^ d3 ^ d4 ^ ODD_PARITY;
    codeword = {d4, d3, d2, p3, d1, p2, p1};
  end

endmodule

// File: rtl/hamming_encoder_7_4_tx.sv
// Serial Hamming(7,4) transmitter: accepts a nibble, shifts its 7-bit codeword out p1 first,
// one bit per enabled cycle, with back-to-back frames when a nibble is offered on the last bit.
module hamming_encoder_7_4_tx
  import hamming_encoder_7_4_tx_pkg::*;
#(
  parameter bit   ODD_PARITY = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [HAM_DATA_LEN-1:0] data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    enc_out,
  output logic                    enc_valid,
  output logic                    frame_start,
  output logic                    busy
);

  // Handshake: a nibble transfers on a rising edge where data_valid and data_ready are both 1;
  // data_ready depends only on ena and frame position, never on data_valid.

  logic [1:0]            state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [HAM_CW_LEN-1:0] shift_q, shift_d;
  logic                  enc_out_q, enc_out_d;
  logic [HAM_CW_LEN-1:0] codeword;
  logic                  last_bit;
  logic                  accept;

  hamming_parity_7_4 #(
    .ODD_PARITY (ODD_PARITY)
  ) u_parity (
    .data     (data_in),
    .codeword (codeword)
  );

  assign last_bit   = (state_q == ST_SHIFT) && (idx_q == HAM_IDX_LAST);
  assign data_ready = !rst && ena && ((state_q == ST_IDLE) || last_bit);
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    enc_out_d = enc_out_q;
    // shift_q holds the bits still to be sent, next one in bit 0; enc_out_q is the bit on the wire.
    if (idx_q > HAM_IDX_LAST) begin
      state_d   = ST_IDLE;
      idx_d     = 3'd0;
      shift_d   = '0;
      enc_out_d = IDLE_LEVEL;
    end else if (ena) begin
      if (accept) begin
        state_d   = ST_SHIFT;
        idx_d     = 3'd0;
        shift_d   = {1'b0, codeword[HAM_CW_LEN-1:1]};
        enc_out_d = codeword[0];
      end else if ((state_q == ST_SHIFT) && !last_bit) begin
        idx_d     = idx_q + 3'd1;
        shift_d   = {1'b0, shift_q[HAM_CW_LEN-1:1]};
        enc_out_d = shift_q[0];
      end else begin
        state_d   = ST_IDLE;
        idx_d     = 3'd0;
        shift_d   = '0;
        enc_out_d = IDLE_LEVEL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      shift_q   <= '0;
      enc_out_q <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      enc_out_q <= enc_out_d;
    end
  end

  assign enc_out     = enc_out_q;
  assign busy        = (state_q == ST_SHIFT);
  assign enc_valid   = busy;
  assign frame_start = busy && (idx_q == 3'd0);

endmodule

// File: tb/tb_hamming_encoder_7_4_tx.sv
// Bench for hamming_encoder_7_4_tx: even and odd parity instances share stimulus and are checked
// against a position-based Hamming model, a bit queue scoreboard and a serial syndrome decoder.
module tb_hamming_encoder_7_4_tx;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready, enc_out, enc_valid, frame_start, busy;
  logic       o_data_ready, o_enc_out, o_enc_valid, o_frame_start, o_busy;

  int checks   = 0;
  int failures = 0;

  logic [0:0] exp_q[$];
  logic [0:0] exp_odd_q[$];
  logic [3:0] sent_q[$];
  logic       m_bit, m_odd_bit, m_busy, m_first;
  logic [6:0] rx_even, rx_odd, last_even, last_odd;
  int         rx_cnt;
  logic       acc;

  hamming_encoder_7_4_tx #(.ODD_PARITY(1'b0), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .enc_out(enc_out), .enc_valid(enc_valid),
    .frame_start(frame_start), .busy(busy)
  );

  hamming_encoder_7_4_tx #(.ODD_PARITY(1'b1), .IDLE_LEVEL(1'b0)) dut_odd (
    .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .data_valid(data_valid),
    .data_ready(o_data_ready), .enc_out(o_enc_out), .enc_valid(o_enc_valid),
    .frame_start(o_frame_start), .busy(o_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Codeword indexed by Hamming position 1..7: data at non-powers of two, parity at 1,2,4
  // covering every position whose index has that bit set.
  function automatic logic [7:1] encode(input logic [3:0] d, input logic odd);
    logic [7:1] w;
    int dpos[4] = '{3, 5, 6, 7};
    logic par;
    w = '0;
    for (int k = 0; k < 4; k++) w[dpos[k]] = d[k];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = odd;
      for (int j = 1; j <= 7; j++)
        if (((j & p) != 0) && (j != p)) par = par ^ w[j];
      w[p] = par;
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_odd_q.delete();
    sent_q.delete();
    m_bit = 1'b0; m_odd_bit = 1'b0; m_busy = 1'b0; m_first = 1'b0;
    rx_cnt = 0; rx_even = '0; rx_odd = '0;
  endtask

  task automatic check_outputs();
    check("enc_out", enc_out, m_busy ? m_bit : 1'b0);
    check("enc_valid", enc_valid, m_busy);
    check("busy", busy, m_busy);
    check("frame_start", frame_start, m_first);
    check("odd_enc_out", o_enc_out, m_busy ? m_odd_bit : 1'b0);
    check("odd_enc_valid", o_enc_valid, m_busy);
    check("odd_frame_start", o_frame_start, m_first);
  endtask

  // Serial decoder: syndrome over set positions, then pull d1..d4 from positions 3,5,6,7.
  task automatic rx_decode();
    logic [7:1] w;
    logic [2:0] syn;
    logic [3:0] got;
    logic [3:0] want;
    for (int j = 1; j <= 7; j++) w[j] = rx_even[7-j];
    syn = 3'd0;
    for (int j = 1; j <= 7; j++) if (w[j]) syn = syn ^ 3'(j);
    got = {w[7], w[6], w[5], w[3]};
    want = (sent_q.size() > 0) ? sent_q.pop_front() : 4'bxxxx;
    check("loop_syndrome", {29'd0, syn}, 32'd0);
    check("loop_nibble", {28'd0, got}, {28'd0, want});
  endtask

  // Driver + model step: enter at a negedge, leave at the next negedge.
  task automatic cycle(input logic en, input logic vld, input logic [3:0] d, output logic a);
    logic exp_ready;
    logic [7:1] cw, cwo;
    ena = en; data_valid = vld; data_in = d;
    #1;
    exp_ready = en && (exp_q.size() == 0);
    check("data_ready", data_ready, exp_ready);
    check("odd_data_ready", o_data_ready, exp_ready);
    a = vld && exp_ready;
    @(posedge clk);
    if (en) begin
      if (a) begin
        cw = encode(d, 1'b0);
        cwo = encode(d, 1'b1);
        for (int j = 1; j <= 7; j++) begin
          exp_q.push_back(cw[j]);
          exp_odd_q.push_back(cwo[j]);
        end
        sent_q.push_back(d);
      end
      if (exp_q.size() > 0) begin
        m_bit = exp_q.pop_front();
        m_odd_bit = exp_odd_q.pop_front();
        m_busy = 1'b1;
        m_first = a;
      end else begin
        m_busy = 1'b0; m_first = 1'b0; m_bit = 1'b0; m_odd_bit = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
    if (en && enc_valid) begin
      if (frame_start) rx_cnt = 0;
      rx_even = {rx_even[5:0], enc_out};
      rx_odd  = {rx_odd[5:0], o_enc_out};
      rx_cnt++;
      if (rx_cnt == 7) begin
        last_even = rx_even;
        last_odd  = rx_odd;
        rx_decode();
        rx_cnt = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; data_valid = 1'b0; data_in = 4'd0;
    model_reset();
    last_even = '0; last_odd = '0;
    @(negedge clk);
    check_outputs();
    check("reset_data_ready", data_ready, 1'b0);
    rst = 1'b0;

    // Test 2: single frame of 1011, then idle
    cycle(1'b1, 1'b1, 4'b1011, acc);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0000, acc);
    check("frame_1011", {25'd0, last_even}, {25'd0, 7'b1010101});

    // Test 3: 0001 then 1111 back-to-back with valid held
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, 1'b1, 4'b0001, acc);
    check("frame_0001_accept", acc, 1'b1);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, 1'b1, 4'b1111, acc);
    check("frame_0001", {25'd0, last_even}, {25'd0, 7'b1110000});
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0000, acc);
    check("frame_1111", {25'd0, last_even}, {25'd0, 7'b1111111});

    // Test 5: odd parity instance on 0000
    cycle(1'b1, 1'b1, 4'b0000, acc);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0000, acc);
    check("odd_frame_0000", {25'd0, last_odd}, {25'd0, 7'b1101000});

    // Test 4: stall with ena pattern 1,0,0,1 and data 0000 offered continuously
    for (int i = 0; i < 40; i++) cycle((i % 4 == 0) || (i % 4 == 3), 1'b1, 4'b0000, acc);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0000, acc);

    // Test 1: reset in the middle of a frame
    cycle(1'b1, 1'b1, 4'b0110, acc);
    cycle(1'b1, 1'b0, 4'b0000, acc);
    cycle(1'b1, 1'b0, 4'b0000, acc);
    ena = 1'b1; data_valid = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("rst_data_ready", data_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    #1;
    check("post_rst_data_ready", data_ready, 1'b1);
    data_valid = 1'b0;
    @(negedge clk);
    check_outputs();

    // Test 6: loopback of all 16 nibbles back-to-back
    for (int n = 0; n < 16; n++) begin
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, 1'b1, 4'(n), acc);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0000, acc);
    check("loopback_drained", sent_q.size(), 0);

    // Randomized traffic with stalls
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), acc);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0000, acc);
    check("random_drained", sent_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
